enc83_seq_scanner: RTL
======================

Name: enc83_seq_scanner

Overview:
- Sequential 8-to-3 priority encoder; the inverse companion of the team's 3-to-8 decoder datapath.
- Accepts an 8-bit request vector over a valid/ready handshake.
- Emits the 3-bit index of every set bit, one index per accepted output beat, highest priority first.
- Sits between the request/event sources and any consumer that needs binary indices, such as decoder-based arithmetic or a select mux.

Parameters:
- N, 8, request vector width. Fixed at 8 for this block; exists only for package consistency.
- IDX_W, 3, index width, equal to clog2(N). Derived; do not override.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request vector present
- req_ready  output  1  block can accept a vector
- req_vec  input  8  request bits; bit 7 is highest priority by default
- idx_valid  output  1  idx/idx_last valid
- idx_ready  input  1  consumer accepts current beat
- idx  output  3  binary index of the current highest-priority pending bit
- idx_last  output  1  current beat is the final set bit of the vector
- busy  output  1  high while in SCAN

Behaviour:
- Reset (async assert, sync release): state=IDLE, pending=8'h00, req_ready=1, idx_valid=0, idx=0, idx_last=0, busy=0.
- States: IDLE, SCAN.
- IDLE:
  - req_ready=1, idx_valid=0.
  - On req_valid&&req_ready with req_vec!=0: pending<=req_vec, go to SCAN.
  - On req_valid&&req_ready with req_vec==0: the handshake completes, the vector is dropped, no output beat is produced, and the block stays in IDLE.
- SCAN:
  - req_ready=0, busy=1, idx_valid=1.
  - idx = position of the highest set bit of pending.
  - idx_last=1 iff pending has exactly one bit set.
  - idx and idx_last are driven from registered pending through the priority encoder (combinational from state). They must remain stable while idx_valid && !idx_ready.
  - On idx_valid&&idx_ready: clear bit idx in pending. If idx_last, go to IDLE (pending becomes 0); otherwise stay in SCAN.
- Latency:
  - First idx_valid appears 1 cycle after the req handshake cycle.
  - With idx_ready held high, a vector with k set bits yields k consecutive beats.
  - req_ready returns the cycle after the last beat.
  - Throughput is k+1 cycles per vector.
- No overlap: a new request is never accepted in the same cycle as the last output beat.
- Back-pressure: idx_ready low holds state indefinitely. idx_valid never drops without a handshake.
- req_vec is sampled only on the handshake cycle; later changes to req_vec are ignored.
- Reset mid-SCAN: pending is discarded immediately and outputs return to reset values asynchronously.
- idx_ready while idx_valid=0 has no effect.

Optional Feature:
- Macro: ENC83_LSB_FIRST_EN.
- Defined: priority is reversed. idx is the lowest set bit of pending, so bit 0 is served first; all handshake and timing rules are unchanged.
- Undefined: MSB-first as described above.

Decomposition:
- Package enc83_pkg holds:
  - localparams N=8 and IDX_W=3;
  - state typedef {IDLE, SCAN};
  - function onehot_or_zero(vec) used for idx_last.
- One sub-module, pri_enc83:
  - purely combinational 8-bit priority encoder;
  - outputs idx[2:0], any and single;
  - honours ENC83_LSB_FIRST_EN.
- The top module holds the FSM, the pending register and the handshake logic.

Test Plan:
1. After reset: req_ready=1, idx_valid=0, idx=0, busy=0. Assert rst_n low mid-SCAN with pending=8'hA5 -> outputs return to reset values immediately. After release, the next vector is processed cleanly.
2. req_vec=8'b1010_0101, idx_ready=1 constant (MSB-first build).
   - idx sequence is 7,5,2,0 on consecutive cycles.
   - idx_last=1 only on idx=0.
   - req_ready=1 on the cycle after that beat.
3. req_vec=8'h00 handshake -> no idx_valid ever, busy stays 0, req_ready stays 1.
4. req_vec=8'h90, idx_ready low for 5 cycles then high.
   - idx=7 is held stable with idx_valid=1 for all 5 cycles.
   - Then the beats are 7, then 4 with idx_last=1.
   - Changing req_vec to 8'hFF during SCAN has no effect.
5. req_vec=8'h01 -> single beat idx=0, idx_last=1. req_vec=8'hFF back-to-back -> 8 beats 7..0, with exactly one IDLE cycle between vectors.
6. ENC83_LSB_FIRST_EN defined, req_vec=8'b1010_0101 -> idx sequence 0,2,5,7, idx_last on idx=7.

Source files
------------

// File: rtl/enc83_pkg.sv
// Shared constants, FSM state type and bit-count helper for the 8-to-3 sequential scanner.
package enc83_pkg;

    localparam int N     = 8;
    localparam int IDX_W = $clog2(N);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // True when vec has at most one bit set; callers qualify with |vec for "exactly one".
    function automatic logic onehot_or_zero(input logic [N-1:0] vec);
        return (vec & (vec - N'(1))) == '0;
    endfunction

endpackage

// File: rtl/enc83_seq_scanner_pri_enc83.sv
// Combinational 8-bit priority encoder: MSB wins by default, LSB wins when
// ENC83_LSB_FIRST_EN is defined.
module pri_enc83
    import enc83_pkg::*;
(
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             single
);

    // The last match in loop order wins, so loop direction sets priority.
    always_comb begin
        idx = '0;
`ifdef ENC83_LSB_FIRST_EN
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W'(i);
        end
`else
        for (int i = 0; i < N; i++) begin
            if (vec[i]) idx = IDX_W'(i);
        end
`endif
        any    = |vec;
        single = any && onehot_or_zero(vec);
    end

endmodule

// File: rtl/enc83_seq_scanner.sv
// Sequential 8-to-3 encoder: accepts a request vector, emits one index beat per set bit.
// Scan order is MSB-first, or LSB-first when ENC83_LSB_FIRST_EN is defined.
//
// state | meaning
// IDLE  | ready for a new vector, pending is empty
// SCAN  | emitting one index per accepted beat from pending
module enc83_seq_scanner
    import enc83_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [N-1:0]     req_vec,
    output logic             idx_valid,
    input  logic             idx_ready,
    output logic [IDX_W-1:0] idx,
    output logic             idx_last,
    output logic             busy
);

    state_t           state;
    logic [N-1:0]     pending;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;
    logic             enc_single;

    pri_enc83 u_pri_enc83 (
        .vec    (pending),
        .idx    (enc_idx),
        .any    (enc_any),
        .single (enc_single)
    );

    // pending is zero outside SCAN, so idx/idx_last naturally read 0 when idle.
    assign idx      = enc_idx;
    assign idx_last = enc_single;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pending   <= '0;
            req_ready <= 1'b1;
            idx_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // An all-zero vector completes the handshake and is dropped.
                    if (req_valid && req_ready && (req_vec != '0)) begin
                        pending   <= req_vec;
                        state     <= SCAN;
                        req_ready <= 1'b0;
                        idx_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                SCAN: begin
                    if (idx_ready && enc_any) begin
                        if (enc_single) begin
                            pending   <= '0;
                            state     <= IDLE;
                            req_ready <= 1'b1;
                            idx_valid <= 1'b0;
                            busy      <= 1'b0;
                        end else begin
                            pending <= pending & ~(N'(1) << enc_idx);
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    pending   <= '0;
                    req_ready <= 1'b1;
                    idx_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
